// File: rtl/reg_file_mem.sv
// reg_file_mem: DEPTH x WIDTH register file with one write port, two independent
// registered read ports, write-to-read bypass and a one-entry-per-cycle clear sweep.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data write port; accepted only while idle and wr_addr < DEPTH
//   rd_addr_a/rd_data_a   read port A, one-cycle latency, registered output
//   rd_addr_b/rd_data_b   read port B, one-cycle latency, registered output
//   clr_start             start a clear sweep (sampled only when idle)
//   busy                  high while the sweep runs (exactly DEPTH cycles)
//   clr_done              one-cycle pulse after the sweep completes
module reg_file_mem #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done
);

  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0]  rd_data_b_q, rd_data_b_d;
  logic              busy_q, busy_d;
  logic              clr_done_q, clr_done_d;

  logic              wr_accept;
  logic [DEPTH-1:0]  wr_hit;   // entry written at this edge
  logic [DEPTH-1:0]  clr_hit;  // entry zeroed by the sweep at this edge

  // Out-of-range addresses match no entry, so they need no separate range check:
  // writes to them fall away and reads of them return zero.
  assign wr_accept = wr_en && (state_q == StIdle);

  always_comb begin
    wr_hit  = '0;
    clr_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_hit[i]  = wr_accept && (wr_addr == ADDR_W'(i));
      clr_hit[i] = (state_q == StClear) && (ptr_q == ADDR_W'(i));
    end
  end

  // Storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_hit[i]) begin
          mem_q[i] <= '0;
        end else if (wr_hit[i]) begin
          mem_q[i] <= wr_data;
        end
      end
    end
  end

  // Read ports: sweep zeroing beats bypass, bypass beats stored contents.
  always_comb begin
    rd_data_a_d = '0;
    rd_data_b_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_a == ADDR_W'(i)) begin
        if (clr_hit[i])     rd_data_a_d = '0;
        else if (wr_hit[i]) rd_data_a_d = wr_data;
        else                rd_data_a_d = mem_q[i];
      end
      if (rd_addr_b == ADDR_W'(i)) begin
        if (clr_hit[i])     rd_data_b_d = '0;
        else if (wr_hit[i]) rd_data_b_d = wr_data;
        else                rd_data_b_d = mem_q[i];
      end
    end
  end

  // Clear FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      clr_done_q  <= 1'b0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      clr_done_q  <= clr_done_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
    end
  end

  // Clear FSM: next state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (clr_start) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      StClear: begin
        if (ptr_q == LastPtr) begin
          state_d = StDone;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Clear FSM: outputs, decoded from the next state so they register with it
  always_comb begin
    busy_d     = (state_d == StClear);
    clr_done_d = (state_d == StDone);
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign busy      = busy_q;
  assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_reg_file_mem.sv
// Testbench for reg_file_mem: a default instance (8x4) and a 16x6 instance driven from a
// shared clock/reset, checked every cycle against an array-based reference model plus
// directed constant checks.
module tb_reg_file_mem;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance 0: WIDTH=8, DEPTH=4, ADDR_W=2
  logic       wr_en0, clr_start0, busy0, clr_done0;
  logic [1:0] wr_addr0, rd_addr_a0, rd_addr_b0;
  logic [7:0] wr_data0, rd_data_a0, rd_data_b0;

  // Instance 1: WIDTH=16, DEPTH=6, ADDR_W=3
  logic        wr_en1, clr_start1, busy1, clr_done1;
  logic [2:0]  wr_addr1, rd_addr_a1, rd_addr_b1;
  logic [15:0] wr_data1, rd_data_a1, rd_data_b1;

  reg_file_mem dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .rd_addr_a(rd_addr_a0), .rd_data_a(rd_data_a0), .rd_addr_b(rd_addr_b0),
    .rd_data_b(rd_data_b0), .clr_start(clr_start0), .busy(busy0), .clr_done(clr_done0)
  );

  reg_file_mem #(.WIDTH(16), .DEPTH(6), .ADDR_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .rd_addr_a(rd_addr_a1), .rd_data_a(rd_data_a1), .rd_addr_b(rd_addr_b1),
    .rd_data_b(rd_data_b1), .clr_start(clr_start1), .busy(busy1), .clr_done(clr_done1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_clr_next: index the sweep zeroes at the next edge, -1 when no sweep is running.
  logic [15:0] m_mem [2][8];
  logic [15:0] m_rd_a [2];
  logic [15:0] m_rd_b [2];
  int          m_clr_next [2];
  bit          m_done [2];

  function automatic int depth_of(input int d);
    return (d == 0) ? 4 : 6;
  endfunction

  function automatic logic [15:0] model_read(input int d, input int ra, input bit wok,
                                             input int wa, input logic [15:0] wd,
                                             input int clr);
    if (ra >= depth_of(d)) return 16'h0;
    if (clr == ra)         return 16'h0;
    if (wok && wa == ra)   return wd;
    return m_mem[d][ra];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) m_mem[d][i] = 16'h0;
      m_rd_a[d]     = 16'h0;
      m_rd_b[d]     = 16'h0;
      m_clr_next[d] = -1;
      m_done[d]     = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input bit we, input int wa, input logic [15:0] wd,
                            input int ra, input int rb, input bit cs);
    int clr;
    bit idle, wok;
    clr  = m_clr_next[d];
    idle = (clr < 0) && !m_done[d];
    wok  = we && idle && (wa < depth_of(d));
    m_rd_a[d] = model_read(d, ra, wok, wa, wd, clr);
    m_rd_b[d] = model_read(d, rb, wok, wa, wd, clr);
    if (wok) m_mem[d][wa] = wd;
    if (clr >= 0) begin
      m_mem[d][clr] = 16'h0;
      if (clr == depth_of(d) - 1) begin
        m_clr_next[d] = -1;
        m_done[d]     = 1'b1;
      end else begin
        m_clr_next[d] = clr + 1;
      end
    end else if (m_done[d]) begin
      m_done[d] = 1'b0;
    end else if (cs) begin
      m_clr_next[d] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(0, wr_en0, int'(wr_addr0), {8'h0, wr_data0}, int'(rd_addr_a0),
                 int'(rd_addr_b0), clr_start0);
      model_step(1, wr_en1, int'(wr_addr1), wr_data1, int'(rd_addr_a1),
                 int'(rd_addr_b1), clr_start1);
    end
  end

  task automatic check_all();
    check_eq("m0_rd_a", rd_data_a0, m_rd_a[0]);
    check_eq("m0_rd_b", rd_data_b0, m_rd_b[0]);
    check_eq("m0_busy", busy0, (m_clr_next[0] >= 0));
    check_eq("m0_done", clr_done0, m_done[0]);
    check_eq("m1_rd_a", rd_data_a1, m_rd_a[1]);
    check_eq("m1_rd_b", rd_data_b1, m_rd_b[1]);
    check_eq("m1_busy", busy1, (m_clr_next[1] >= 0));
    check_eq("m1_done", clr_done1, m_done[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic wr0(input logic [1:0] a, input logic [7:0] v);
    wr_en0 = 1'b1; wr_addr0 = a; wr_data0 = v;
    tick();
    wr_en0 = 1'b0;
  endtask

  // Waits (bounded) for clr_done on instance d, returning the busy-cycle count seen.
  task automatic wait_done(input int d, output int busy_cycles);
    busy_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      if ((d == 0) ? clr_done0 : clr_done1) break;
      if ((d == 0) ? busy0 : busy1) busy_cycles++;
      tick();
    end
    check_eq("sweep_done_seen", (d == 0) ? clr_done0 : clr_done1, 1);
  endtask

  int nb;

  initial begin
    rst_n = 1'b0;
    wr_en0 = 0; wr_addr0 = 0; wr_data0 = 0; rd_addr_a0 = 0; rd_addr_b0 = 0; clr_start0 = 0;
    wr_en1 = 0; wr_addr1 = 0; wr_data1 = 0; rd_addr_a1 = 0; rd_addr_b1 = 0; clr_start1 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rd_a", rd_data_a0, 0);
    check_eq("rst_busy", busy0, 0);
    check_eq("rst_done", clr_done0, 0);
    rst_n = 1'b1;

    // Every address reads zero before any write
    for (int i = 0; i < 4; i++) begin
      rd_addr_a0 = 2'(i); rd_addr_b0 = 2'(3 - i);
      tick();
      check_eq("init_a", rd_data_a0, 0);
      check_eq("init_b", rd_data_b0, 0);
    end

    // Basic write then read on both ports
    wr0(2'd2, 8'hA5);
    wr0(2'd1, 8'h3C);
    rd_addr_a0 = 2'd2; rd_addr_b0 = 2'd1;
    tick();
    check_eq("read_a5", rd_data_a0, 8'hA5);
    check_eq("read_3c", rd_data_b0, 8'h3C);

    // Write-first bypass
    wr0(2'd3, 8'h11);
    rd_addr_a0 = 2'd3;
    wr0(2'd3, 8'h77);
    check_eq("bypass_a", rd_data_a0, 8'h77);
    rd_addr_b0 = 2'd3;
    tick();
    check_eq("after_bypass_b", rd_data_b0, 8'h77);

    // Clear sweep with a dropped write while busy
    for (int i = 0; i < 4; i++) wr0(2'(i), 8'(i + 1));
    clr_start0 = 1'b1;
    tick();
    clr_start0 = 1'b0;
    nb = 0;
    for (int k = 0; k < 20 && !clr_done0; k++) begin
      if (busy0) nb++;
      wr_en0 = (k == 1); wr_addr0 = 2'd0; wr_data0 = 8'hFF;
      tick();
    end
    wr_en0 = 1'b0;
    check_eq("clr_busy_cycles", nb, 4);
    check_eq("clr_done_pulse", clr_done0, 1);
    check_eq("busy_in_done", busy0, 0);
    tick();
    check_eq("clr_done_falls", clr_done0, 0);
    for (int i = 0; i < 4; i++) begin
      rd_addr_a0 = 2'(i);
      tick();
      check_eq("cleared_entry", rd_data_a0, 0);
    end

    // Write and clr_start at the same edge
    wr_en0 = 1'b1; wr_addr0 = 2'd0; wr_data0 = 8'h55; clr_start0 = 1'b1;
    tick();
    wr_en0 = 1'b0; clr_start0 = 1'b0;
    check_eq("simul_busy", busy0, 1);
    wait_done(0, nb);
    tick();
    rd_addr_a0 = 2'd0;
    tick();
    check_eq("simul_addr0", rd_data_a0, 0);

    // Asynchronous reset on the second busy cycle
    wr0(2'd3, 8'h99);
    rd_addr_a0 = 2'd3; rd_addr_b0 = 2'd3;
    clr_start0 = 1'b1;
    tick();
    clr_start0 = 1'b0;
    tick();
    check_eq("pre_rst_busy", busy0, 1);
    check_eq("pre_rst_rd_a", rd_data_a0, 8'h99);
    #3 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy0, 0);
    check_eq("mid_rst_done", clr_done0, 0);
    check_eq("mid_rst_rd_a", rd_data_a0, 0);
    check_eq("mid_rst_rd_b", rd_data_b0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wr0(2'd1, 8'h12);
    rd_addr_a0 = 2'd1;
    tick();
    check_eq("post_rst_read", rd_data_a0, 8'h12);
    check_eq("post_rst_idle", busy0, 0);

    // 16x6 instance
    wr_en1 = 1'b1; wr_addr1 = 3'd5; wr_data1 = 16'hBEEF;
    tick();
    wr_addr1 = 3'd7; wr_data1 = 16'h1234;
    rd_addr_a1 = 3'd5;
    tick();
    wr_en1 = 1'b0;
    check_eq("w16_beef", rd_data_a1, 16'hBEEF);
    rd_addr_a1 = 3'd7;
    tick();
    check_eq("w16_oob", rd_data_a1, 16'h0000);
    clr_start1 = 1'b1;
    tick();
    clr_start1 = 1'b0;
    wait_done(1, nb);
    check_eq("w16_busy_cycles", nb, 6);

    // Randomized traffic on both instances
    for (int n = 0; n < 600; n++) begin
      wr_en0     = 1'($urandom_range(0, 1));
      wr_addr0   = 2'($urandom_range(0, 3));
      wr_data0   = 8'($urandom);
      rd_addr_a0 = 2'($urandom_range(0, 3));
      rd_addr_b0 = 2'($urandom_range(0, 3));
      clr_start0 = ($urandom_range(0, 19) == 0);
      wr_en1     = 1'($urandom_range(0, 1));
      wr_addr1   = 3'($urandom_range(0, 7));
      wr_data1   = 16'($urandom);
      rd_addr_a1 = 3'($urandom_range(0, 7));
      rd_addr_b1 = 3'($urandom_range(0, 7));
      clr_start1 = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
